npc_predict: RTL
================

Name: npc_predict

Overview:
- Parametrised successor to the combinational next-PC logic.
- Owns the fetch PC register and computes the next fetch address every cycle.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters for next-PC prediction.
- Accepts branch/jump resolution from the D stage and exception/eret redirects, and raises a flush when fetch was wrong.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, target on exception request.
- BTB_ENTRIES, 16, BTB depth; power of two, 2..256; IDX_W = log2(BTB_ENTRIES).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the PC (hazard stall).
- exc_req  in  1  exception taken this cycle.
- eret_req  in  1  return from exception.
- epc  in  32  eret target.
- res_valid  in  1  D stage is resolving a control-transfer instruction this cycle.
- res_pc  in  32  PC of the resolving instruction.
- res_taken  in  1  actual direction; 1 for unconditional jumps.
- res_target  in  32  actual taken target; bits [1:0] ignored.
- res_pred_taken  in  1  prediction carried down the pipe with that instruction.
- res_pred_target  in  32  predicted target carried with it.
- if_pc  out  32  current fetch PC.
- if_pc_add4  out  32  if_pc + 4.
- pred_taken  out  1  BTB prediction for if_pc.
- pred_target  out  32  predicted target for if_pc; valid when pred_taken = 1.
- flush  out  1  kill the IF/ID contents; combinational, same cycle as the redirect.

Behaviour:
- Reset: if_pc = RESET_PC, all BTB valid bits cleared, counters = 2'b00. Reset mid-operation discards any pending redirect.
- Combinational outputs after reset: pred_taken = 0, flush = 0 when inputs are idle.
- mispredict = res_valid & ((res_taken != res_pred_taken) | (res_taken & ({res_target[31:2],2'b00} != res_pred_target))).
- flush = exc_req | eret_req | mispredict.
- Next PC, strict priority:
  1. reset → RESET_PC.
  2. exc_req → EXC_VECTOR.
  3. eret_req → epc.
  4. mispredict → res_taken ? res_target : res_pc+4.
  5. stall → hold.
  6. pred_taken → pred_target.
  7. otherwise → if_pc+4.
- Redirects override stall. There is no delay slot.
- Output alignment: if_pc[1:0] is always 2'b00; targets are forced to a 4-byte boundary.
- Arithmetic: all adds are 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- BTB entry fields: valid, tag = pc[31:IDX_W+2], target[31:2], ctr[1:0]. Index = pc[IDX_W+1:2].
- BTB lookup (combinational on if_pc): pred_taken = valid & tag match & ctr[1]; pred_target = {target,2'b00}.
- BTB update, on res_valid only, at the clock edge:
  - Hit: ctr saturating ++ if taken, -- if not taken; target rewritten when taken.
  - Miss & taken: allocate/overwrite the entry with valid = 1, new tag and target, ctr = 2'b10.
  - Miss & not taken: no change.
- BTB updates are suppressed when exc_req = 1 in the same cycle, since the instruction is cancelled.
- A lookup and an update to the same index in the same cycle: the lookup sees the pre-update contents.
- Latency: prediction is zero-cycle (same cycle as if_pc). A redirect takes effect on if_pc at the next edge.

Optional Feature:
- NPC_BTB_EN defined: BTB as described.
- Undefined: no BTB storage; pred_taken = 0 and pred_target = if_pc+4.
  - mispredict reduces to res_valid & res_taken.
  - Ports stay unchanged.

Decomposition:
- Package npc_pkg holds:
  - counter encodings: SNT = 00, WNT = 01, WT = 10, ST = 11;
  - default RESET_PC and EXC_VECTOR localparams;
  - the redirect-cause enum: NONE, EXC, ERET, MISPRED.
- One sub-module, npc_btb: storage, lookup and update logic, parameterised by BTB_ENTRIES.
- Top level holds the PC register, priority mux and flush.

Test Plan:
- Reset, then 3 idle cycles → if_pc = 0x3000, 0x3004, 0x3008; pred_taken = 0; flush = 0.
- Taken branch at 0x3010 to 0x3040, unpredicted → flush = 1, next if_pc = 0x3040. The next fetch of 0x3010 gives pred_taken = 1, pred_target = 0x3040.
- Same branch resolves not taken twice after allocation → ctr goes 10 → 01 → 00, and pred_taken at 0x3010 goes to 0. The first not-taken resolution with res_pred_taken = 1 redirects to 0x3014 with flush = 1.
- stall = 1 for 2 cycles at 0x3020 → if_pc held; mispredict during the stall → redirect still taken.
- exc_req, eret_req and mispredict in the same cycle → if_pc = 0x4180, no BTB update. Then eret_req with epc = 0x3024 → if_pc = 0x3024.
- Aliasing with BTB_ENTRIES = 16: branch 0x3010 allocated, then taken branch 0x3050 (same index, different tag) → entry overwritten. Lookup at 0x3010 misses.

Source files
------------

// File: rtl/npc_pkg.sv
// npc_pkg: shared types, default addresses and counter helpers for the next-PC predictor
package npc_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
  typedef enum logic [1:0] {NONE, EXC, ERET, MISPRED} redirect_e;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
  function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
    return taken ? (c == ST ? ST : ctr_e'(c + 2'd1)) : (c == SNT ? SNT : ctr_e'(c - 2'd1));
  endfunction
endpackage

// File: rtl/npc_btb.sv
// npc_btb: direct-mapped branch target buffer with 2-bit counters; only built when NPC_BTB_EN is defined
`ifdef NPC_BTB_EN
module npc_btb
  import npc_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] lk_pc,
  input  logic        upd_en,
  input  logic [31:2] upd_pc,
  input  logic        upd_taken,
  input  logic [31:2] upd_target,
  output logic        hit_taken,
  output logic [31:0] hit_target
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [29:0]            tgt_q [BTB_ENTRIES];
  ctr_e                   ctr_q [BTB_ENTRIES];
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;
  always_comb begin
    lk_idx     = lk_pc[IDX_W+1:2];
    lk_tag     = lk_pc[31:IDX_W+2];
    up_idx     = upd_pc[IDX_W+1:2];
    up_tag     = upd_pc[31:IDX_W+2];
    up_hit     = valid_q[up_idx] && tag_q[up_idx] == up_tag;
    hit_taken  = valid_q[lk_idx] && tag_q[lk_idx] == lk_tag && ctr_q[lk_idx][1];
    hit_target = {tgt_q[lk_idx], 2'b00};
  end
  // a miss only allocates when taken; a hit always trains the counter
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= SNT;
      end
    end else if (upd_en && (up_hit || upd_taken)) begin
      valid_q[up_idx] <= 1'b1;
      ctr_q[up_idx]   <= up_hit ? ctr_step(ctr_q[up_idx], upd_taken) : WT;
      if (upd_taken) begin
        tag_q[up_idx] <= up_tag;
        tgt_q[up_idx] <= upd_target;
      end
    end
  end
endmodule
`endif

// File: rtl/npc_predict.sv
// npc_predict: fetch PC register, prioritised next-PC mux and flush; BTB prediction enabled by NPC_BTB_EN
module npc_predict
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR  = DEF_EXC_VECTOR,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        res_pred_taken,
  input  logic [31:0] res_pred_target,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_add4,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        flush
);
  logic [31:2] pc_q, next_pc, redir_pc;
  logic        mispredict;
  redirect_e   cause;
  logic        unused_bits;
  assign if_pc      = {pc_q, 2'b00};
  assign if_pc_add4 = {pc_q + 30'd1, 2'b00};
`ifdef NPC_BTB_EN
  npc_btb #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk       (clk),
    .reset     (reset),
    .lk_pc     (pc_q),
    .upd_en    (res_valid & ~exc_req),
    .upd_pc    (res_pc[31:2]),
    .upd_taken (res_taken),
    .upd_target(res_target[31:2]),
    .hit_taken (pred_taken),
    .hit_target(pred_target)
  );
  assign mispredict  = res_valid & ((res_taken != res_pred_taken) |
                       (res_taken & ({res_target[31:2], 2'b00} != res_pred_target)));
  assign unused_bits = ^{epc[1:0], res_pc[1:0], res_target[1:0]};
`else
  assign pred_taken  = 1'b0;
  assign pred_target = if_pc_add4;
  assign mispredict  = res_valid & res_taken;
  assign unused_bits = ^{epc[1:0], res_pc[1:0], res_target[1:0], res_pred_taken, res_pred_target};
`endif
  always_comb begin
    cause    = exc_req ? EXC : eret_req ? ERET : mispredict ? MISPRED : NONE;
    redir_pc = res_taken ? res_target[31:2] : res_pc[31:2] + 30'd1;
    next_pc  = cause == EXC     ? EXC_VECTOR[31:2] :
               cause == ERET    ? epc[31:2] :
               cause == MISPRED ? redir_pc :
               stall            ? pc_q :
               pred_taken       ? pred_target[31:2] : pc_q + 30'd1;
  end
  assign flush = cause != NONE;
  always_ff @(posedge clk) begin
    pc_q <= reset ? RESET_PC[31:2] : next_pc;
  end
endmodule
